div_iter32: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS execute stage. It implements the responder side of the execute-stage divide handshake. The execute stage raises `start_i` with the operands and stalls the pipeline until `ready_o` rises. The block then returns `{remainder, quotient}` for DIV (signed) and DIVU (unsigned). It uses restoring radix-2 division, one quotient bit per cycle.

---
 rtl/div_iter32_if.sv | 22 ++
 rtl/div_iter32.sv | 132 +++++++++++++
 tb/tb_div_iter32.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/div_iter32_if.sv
// div_iter32_if: execute-stage divide handshake between the pipeline (master) and the divider (slave)
interface div_iter32_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter32.sv
// div_iter32: multi-cycle restoring radix-2 divider returning {remainder, quotient} for DIV/DIVU
module div_iter32 #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         resetn,
  div_iter32_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               rdy_q, rdy_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+1:0]   shl, diff;
  logic               ge;
  logic [WIDTH:0]     rem_s;
  logic [WIDTH-1:0]   quo_s, q_fix, r_fix;

  // Operand magnitudes; the most negative value maps to itself as an unsigned magnitude
  assign a_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign b_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign a_mag = a_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign b_mag = b_neg ? -bus.opdata2_i : bus.opdata2_i;

  // One restoring step: shift {rem, quo} left, keep the trial difference when it does not borrow
  assign shl   = {rem_q, quo_q[WIDTH-1]};
  assign diff  = shl - {2'b0, dvs_q};
  assign ge    = ~diff[WIDTH+1];
  assign rem_s = ge ? diff[WIDTH:0] : shl[WIDTH:0];
  assign quo_s = {quo_q[WIDTH-2:0], ge};
  assign q_fix = negq_q ? -quo_s : quo_s;
  assign r_fix = negr_q ? -rem_s[WIDTH-1:0] : rem_s[WIDTH-1:0];

  // Next-state logic; annul beats step completion in ON and BYZERO
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            rem_d   = '0;
            quo_d   = a_mag;
            cnt_d   = '0;
          end
        end
      end
      S_BYZERO: begin
        state_d = bus.annul_i ? S_IDLE : S_END;
        res_d   = '0;
        rdy_d   = !bus.annul_i;
      end
      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
          res_d   = '0;
          rdy_d   = 1'b0;
        end else begin
          rem_d = rem_s;
          quo_d = quo_s;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = S_END;
            res_d   = {r_fix, q_fix};
            rdy_d   = 1'b1;
          end
        end
      end
      default: begin
        if (!bus.start_i) begin
          state_d = S_IDLE;
          res_d   = '0;
          rdy_d   = 1'b0;
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.result_o = res_q;
  assign bus.ready_o  = rdy_q;
endmodule

// File: tb/tb_div_iter32.sv
// tb_div_iter32: directed and randomized checks of div_iter32 against an arithmetic reference model
module tb_div_iter32;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  div_iter32_if #(.WIDTH(32)) bus ();

  div_iter32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain truncating division on sign-extended 64-bit values
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  task automatic run(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int cyc;
    exp = model(sgn, a, b);
    launch(sgn, a, b);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.signed_div_i = 1'($urandom);
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
      end
    end while (!bus.ready_o && cyc < 40);
    chk("latency", 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd33);
    chk("result", bus.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      bus.annul_i = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_ready", 64'(bus.ready_o), 64'd1);
      chk("hold_result", bus.result_o, exp);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_ready", 64'(bus.ready_o), 64'd0);
    chk("drop_result", bus.result_o, 64'd0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #12;
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run(1'b0, 32'd100, 32'd7, 0);
    chk("divu_100_7_const", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run(1'b0, 32'hFFFFFFFF, 32'd1, 0);
    run(1'b0, 32'd1234, 32'd0, 5);
    run(1'b1, 32'hFFFFFF00, 32'd0, 5);

    launch(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("annul_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    watch_quiet("annul_never_ready", 40);
    run(1'b0, 32'd9, 32'd4, 0);

    launch(1'b0, 32'd50, 32'd5);
    bus.annul_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    watch_quiet("annul_idle_suppress", 40);

    launch(1'b0, 32'd5000, 32'd7);
    repeat (15) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midop_reset_ready", 64'(bus.ready_o), 64'd0);
    chk("midop_reset_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    launch(1'b0, 32'd77, 32'd5);
    repeat (33) @(posedge clk);
    #1;
    chk("end_ready", 64'(bus.ready_o), 64'd1);
    chk("end_result", bus.result_o, {32'd2, 32'd15});
    #2;
    resetn = 1'b0;
    #1;
    chk("end_reset_ready", 64'(bus.ready_o), 64'd0);
    chk("end_reset_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    run(1'b0, 32'd81, 32'd9, 0);
    run(1'b1, 32'hFFFFFF9C, 32'd7, 0);

    for (int i = 0; i < 25; i++) begin
      bit          sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run(sgn, a, b, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
